// File: rtl/fpu_pkg.sv
// Shared definitions for the custom 32-bit floating-point adder.
// Format: [31] sign, [30:25] exponent (bias 31), [24:0] fraction with hidden 1.
// Provides field widths, bias, status bit indices, the FSM state enum and
// the packed fp_t operand struct.
package fpu_pkg;

  localparam int EXP_W  = 6;
  localparam int FRAC_W = 25;
  localparam int MANT_W = FRAC_W + 1;  // hidden 1 + fraction
  localparam int MAG_W  = MANT_W + 1;  // width seen by the leading-zero counter
  localparam int BIAS   = 31;

  localparam int ST_EXACT     = 3;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_INEXACT   = 0;

  typedef enum logic [2:0] {
    LOAD,
    ALIGN,
    OPERATE,
    NORMALIZE,
    WRITE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter over a 27-bit magnitude.
// Ports:
//   value  in  27  magnitude to scan (MSB first)
//   count  out 5   number of leading zeros; 27 when value is all zero
module fpu_lzc
  import fpu_pkg::*;
(
  input  logic [MAG_W-1:0] value,
  output logic [4:0]       count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 5'(MAG_W);
    for (int unsigned i = 0; i < MAG_W; i++) begin
      if (value[i]) count = 5'(MAG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_adder.sv
// Free-running multi-cycle floating-point adder/subtractor.
// Pass: LOAD -> ALIGN -> OPERATE -> NORMALIZE -> WRITE, one state per cycle.
// Ports:
//   clock       in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   op_A_in     in   32  operand A (sampled only in LOAD)
//   op_B_in     in   32  operand B (sampled only in LOAD)
//   data_out    out  32  registered result, updated in WRITE
//   status_out  out  4   one-hot {EXACT, OVERFLOW, UNDERFLOW, INEXACT}
// Macro: ROUND_NEAREST_EN selects round-to-nearest-even; default truncates.
module fpu_adder
  import fpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] op_A_in,
  input  logic [31:0] op_B_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  state_t state, state_next;
  logic   load_en, align_en, operate_en, normalize_en, write_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = LOAD;
    case (state)
      LOAD:      state_next = ALIGN;
      ALIGN:     state_next = OPERATE;
      OPERATE:   state_next = NORMALIZE;
      NORMALIZE: state_next = WRITE;
      WRITE:     state_next = LOAD;
      default:   state_next = LOAD;
    endcase
  end

  always_comb begin
    load_en      = (state == LOAD);
    align_en     = (state == ALIGN);
    operate_en   = (state == OPERATE);
    normalize_en = (state == NORMALIZE);
    write_en     = (state == WRITE);
  end

  // LOAD: split fields; exponent 0 flushes to zero.
  fp_t              a_in, b_in;
  logic [MANT_W-1:0] a_mant_in, b_mant_in;
  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;

  always_comb begin
    a_in      = op_A_in;
    b_in      = op_B_in;
    a_mant_in = (a_in.exp == '0) ? '0 : {1'b1, a_in.frac};
    b_mant_in = (b_in.exp == '0) ? '0 : {1'b1, b_in.frac};
  end

  // ALIGN: order by magnitude, shift the smaller one right, keep g/r/s.
  logic                a_larger, big_sign, small_sign;
  logic [EXP_W-1:0]    big_exp, small_exp, exp_diff;
  logic [MANT_W-1:0]   big_mant, small_mant;
  logic [2*MANT_W-1:0] ext;
  logic [MANT_W+2:0]   small_ext;

  always_comb begin
    a_larger   = {a_exp, a_mant} >= {b_exp, b_mant};
    big_sign   = a_larger ? a_sign : b_sign;
    small_sign = a_larger ? b_sign : a_sign;
    big_exp    = a_larger ? a_exp  : b_exp;
    small_exp  = a_larger ? b_exp  : a_exp;
    big_mant   = a_larger ? a_mant : b_mant;
    small_mant = a_larger ? b_mant : a_mant;
    exp_diff   = big_exp - small_exp;
    ext        = {small_mant, {MANT_W{1'b0}}} >> exp_diff;
    if (exp_diff >= EXP_W'(MAG_W))
      small_ext = {{(MANT_W+2){1'b0}}, |small_mant};
    else
      small_ext = {ext[2*MANT_W-1:MANT_W-2], |ext[MANT_W-3:0]};
  end

  logic              al_sign, al_sub;
  logic [EXP_W-1:0]  al_exp;
  logic [MANT_W-1:0] al_big;
  logic [MANT_W+2:0] al_small;

  // OPERATE: {carry, mantissa, g, r, s}; the larger magnitude is always the minuend.
  logic [MANT_W+3:0] sum;

  always_comb begin
    if (al_sub) sum = {1'b0, al_big, 3'b000} - {1'b0, al_small};
    else        sum = {1'b0, al_big, 3'b000} + {1'b0, al_small};
  end

  logic              op_sign;
  logic [EXP_W-1:0]  op_exp;
  logic [MANT_W+3:0] op_sum;

  // NORMALIZE: lzc scans mantissa plus guard; a guard-only result (diff of 1,
  // near-total cancellation) still normalizes in one shift.
  logic [4:0]        lzc;
  logic [MANT_W+2:0] shifted;
  logic [MANT_W-1:0] norm_mant;
  logic [2:0]        norm_grs;
  logic signed [7:0] norm_exp;
  logic              norm_zero;

  fpu_lzc u_lzc (
    .value (op_sum[MANT_W+2:2]),
    .count (lzc)
  );

  always_comb begin
    shifted = op_sum[MANT_W+2:0] << lzc;
    if (op_sum[MANT_W+3]) begin
      norm_mant = op_sum[MANT_W+3:4];
      norm_grs  = {op_sum[3], op_sum[2], |op_sum[1:0]};
      norm_exp  = $signed({2'b00, op_exp}) + 8'sd1;
    end else begin
      norm_mant = shifted[MANT_W+2:3];
      norm_grs  = shifted[2:0];
      norm_exp  = $signed({2'b00, op_exp}) - $signed({3'b000, lzc});
    end
    norm_zero = ~op_sum[MANT_W+3] && (lzc == 5'(MAG_W));
  end

  logic              nm_sign, nm_zero;
  logic [MANT_W-1:0] nm_mant;
  logic [2:0]        nm_grs;
  logic signed [7:0] nm_exp;

  // WRITE: optional rounding, then range checks and status.
  logic              round_up, inexact;
  logic [MANT_W:0]   rnd;
  logic [MANT_W-1:0] fin_mant;
  logic signed [7:0] fin_exp;
  logic [31:0]       data_next;
  logic [3:0]        status_next;

  always_comb begin
    inexact = |nm_grs;
`ifdef ROUND_NEAREST_EN
    round_up = nm_grs[2] & (nm_grs[1] | nm_grs[0] | nm_mant[0]);
`else
    round_up = 1'b0;
`endif
    rnd = {1'b0, nm_mant} + {{MANT_W{1'b0}}, round_up};
    if (rnd[MANT_W]) begin
      fin_mant = rnd[MANT_W:1];
      fin_exp  = nm_exp + 8'sd1;
    end else begin
      fin_mant = rnd[MANT_W-1:0];
      fin_exp  = nm_exp;
    end
    data_next   = '0;
    status_next = '0;
    if (nm_zero) begin
      status_next[ST_EXACT] = 1'b1;
    end else if (fin_exp > 8'sd63) begin
      data_next                = {nm_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      status_next[ST_OVERFLOW] = 1'b1;
    end else if (fin_exp < 8'sd1) begin
      status_next[ST_UNDERFLOW] = 1'b1;
    end else begin
      data_next = {nm_sign, fin_exp[EXP_W-1:0], fin_mant[FRAC_W-1:0]};
      if (inexact) status_next[ST_INEXACT] = 1'b1;
      else         status_next[ST_EXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sign     <= 1'b0;
      a_exp      <= '0;
      a_mant     <= '0;
      b_sign     <= 1'b0;
      b_exp      <= '0;
      b_mant     <= '0;
      al_sign    <= 1'b0;
      al_sub     <= 1'b0;
      al_exp     <= '0;
      al_big     <= '0;
      al_small   <= '0;
      op_sign    <= 1'b0;
      op_exp     <= '0;
      op_sum     <= '0;
      nm_sign    <= 1'b0;
      nm_zero    <= 1'b0;
      nm_mant    <= '0;
      nm_grs     <= '0;
      nm_exp     <= '0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      if (load_en) begin
        a_sign <= a_in.sign;
        a_exp  <= a_in.exp;
        a_mant <= a_mant_in;
        b_sign <= b_in.sign;
        b_exp  <= b_in.exp;
        b_mant <= b_mant_in;
      end
      if (align_en) begin
        al_sign  <= big_sign;
        al_sub   <= big_sign ^ small_sign;
        al_exp   <= big_exp;
        al_big   <= big_mant;
        al_small <= small_ext;
      end
      if (operate_en) begin
        op_sign <= al_sign;
        op_exp  <= al_exp;
        op_sum  <= sum;
      end
      if (normalize_en) begin
        nm_sign <= op_sign;
        nm_zero <= norm_zero;
        nm_mant <= norm_mant;
        nm_grs  <= norm_grs;
        nm_exp  <= norm_exp;
      end
      if (write_en) begin
        data_out   <= data_next;
        status_out <= status_next;
      end
    end
  end

endmodule

// File: tb/tb_fpu_adder.sv
// Directed bench for fpu_adder: each task resets, applies one operand pair,
// waits 8 cycles and compares data_out/status_out with hand-computed values.
`timescale 1us/1ns
module tb_fpu_adder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_A_in = '0;
  logic [31:0] op_B_in = '0;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int unsigned checks = 0;
  int unsigned failures = 0;

  fpu_adder dut (
    .clock      (clock),
    .reset      (reset),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  task automatic run_pass(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    reset   = 1'b1;
    op_A_in = a;
    op_B_in = b;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset   = 1'b1;
    op_A_in = 32'h3E000000;
    op_B_in = 32'h3E000000;
    repeat (3) @(negedge clock);
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected %h", data_out, 32'h0);
    end
    checks++;
    if (status_out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_status: got %b expected %b", status_out, 4'b0000);
    end
  endtask

  task automatic test_add_same_sign();
    run_pass(32'hBE000000, 32'hBE000000);
    checks++;
    if (data_out !== 32'hC0000000) begin
      failures++;
      $display("FAIL neg1_plus_neg1_data: got %h expected %h", data_out, 32'hC0000000);
    end
    checks++;
    if (status_out !== 4'b1000) begin
      failures++;
      $display("FAIL neg1_plus_neg1_status: got %b expected %b", status_out, 4'b1000);
    end
  endtask

  task automatic test_sub_diff_sign();
    run_pass(32'h40000000, 32'hC2000000);
    checks++;
    if (data_out !== 32'hC0000000) begin
      failures++;
      $display("FAIL two_minus_four_data: got %h expected %h", data_out, 32'hC0000000);
    end
    checks++;
    if (status_out !== 4'b1000) begin
      failures++;
      $display("FAIL two_minus_four_status: got %b expected %b", status_out, 4'b1000);
    end
  endtask

  task automatic test_cancel();
    run_pass(32'h3E000000, 32'hBE000000);
    checks++;
    if (data_out !== 32'h00000000) begin
      failures++;
      $display("FAIL cancel_data: got %h expected %h", data_out, 32'h0);
    end
    checks++;
    if (status_out !== 4'b1000) begin
      failures++;
      $display("FAIL cancel_status: got %b expected %b", status_out, 4'b1000);
    end
  endtask

  task automatic test_carry();
    run_pass(32'h3F000000, 32'h3C000000);
    checks++;
    if (data_out !== 32'h40000000) begin
      failures++;
      $display("FAIL carry_data: got %h expected %h", data_out, 32'h40000000);
    end
    checks++;
    if (status_out !== 4'b1000) begin
      failures++;
      $display("FAIL carry_status: got %b expected %b", status_out, 4'b1000);
    end
  endtask

  task automatic test_operand_change();
    run_pass(32'h3E000000, 32'h00000000);
    checks++;
    if (data_out !== 32'h3E000000) begin
      failures++;
      $display("FAIL plus_zero_data: got %h expected %h", data_out, 32'h3E000000);
    end
    checks++;
    if (status_out !== 4'b1000) begin
      failures++;
      $display("FAIL plus_zero_status: got %b expected %b", status_out, 4'b1000);
    end
    op_A_in = 32'h3F000000;
    op_B_in = 32'h40400000;
    repeat (10) @(negedge clock);
    checks++;
    if (data_out !== 32'h41C00000) begin
      failures++;
      $display("FAIL change_data: got %h expected %h", data_out, 32'h41C00000);
    end
    checks++;
    if (status_out !== 4'b1000) begin
      failures++;
      $display("FAIL change_status: got %b expected %b", status_out, 4'b1000);
    end
  endtask

  task automatic test_overflow();
    run_pass(32'h7E000000, 32'h7E000000);
    checks++;
    if (data_out !== 32'h7E000000) begin
      failures++;
      $display("FAIL overflow_data: got %h expected %h", data_out, 32'h7E000000);
    end
    checks++;
    if (status_out !== 4'b0100) begin
      failures++;
      $display("FAIL overflow_status: got %b expected %b", status_out, 4'b0100);
    end
  endtask

  task automatic test_inexact();
    // exponent 1 operand is 30 binades below 1.0: fully shifted out into sticky
    run_pass(32'h3E000000, 32'h02000000);
    checks++;
    if (data_out !== 32'h3E000000) begin
      failures++;
      $display("FAIL inexact_data: got %h expected %h", data_out, 32'h3E000000);
    end
    checks++;
    if (status_out !== 4'b0001) begin
      failures++;
      $display("FAIL inexact_status: got %b expected %b", status_out, 4'b0001);
    end
  endtask

  task automatic test_underflow();
    // 1.5*2^-30 - 1.0*2^-30 = 2^-31 -> biased exponent 0
    run_pass(32'h03000000, 32'h82000000);
    checks++;
    if (data_out !== 32'h00000000) begin
      failures++;
      $display("FAIL underflow_data: got %h expected %h", data_out, 32'h0);
    end
    checks++;
    if (status_out !== 4'b0010) begin
      failures++;
      $display("FAIL underflow_status: got %b expected %b", status_out, 4'b0010);
    end
  endtask

  task automatic test_reset_mid_pass();
    run_pass(32'hBE000000, 32'hBE000000);
    checks++;
    if (data_out !== 32'hC0000000) begin
      failures++;
      $display("FAIL midpass_pre_data: got %h expected %h", data_out, 32'hC0000000);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL midpass_reset_data: got %h expected %h", data_out, 32'h0);
    end
    checks++;
    if (status_out !== 4'b0000) begin
      failures++;
      $display("FAIL midpass_reset_status: got %b expected %b", status_out, 4'b0000);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL midpass_hold_data: got %h expected %h", data_out, 32'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_same_sign();
    test_sub_diff_sign();
    test_cancel();
    test_carry();
    test_operand_change();
    test_overflow();
    test_inexact();
    test_underflow();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
